// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared state encoding, requester IDs and size defaults
// Revision        : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational two-way round-robin winner select with lock bursts
// Revision : 1.0
// ============================================================================
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_owner,
    input  logic       i_lock_held,
    input  logic [3:0] i_burst_cnt,
    output logic       o_valid,
    output logic       o_winner
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = REQ_CPU;
        if (i_req0 && !i_req1) begin
            o_winner = REQ_CPU;
        end else if (i_req1 && !i_req0) begin
            o_winner = REQ_IO;
        end else if (i_lock_held && (i_burst_cnt < c_max_burst)) begin
            // a locked owner keeps the memory until its burst allowance runs out
            o_winner = i_last_owner;
        end else begin
            o_winner = ~i_last_owner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester arbiter for a single-port RAM, 3 cycles per access
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic          LOCK0,
    input  logic          LOCK1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_OUT
);

    arb_state_e    state_q, state_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic          lock_lat_q, lock_lat_d;
    logic          lock_held_q, lock_held_d;

    logic          w_pick_valid;
    logic          w_pick;
    logic          w_sel_we;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .i_req0       (REQ0),
        .i_req1       (REQ1),
        .i_last_owner (last_owner_q),
        .i_lock_held  (lock_held_q),
        .i_burst_cnt  (burst_cnt_q),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick)
    );

    always_comb begin
        state_d      = state_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        lock_lat_d   = lock_lat_q;
        lock_held_d  = lock_held_q;
        w_sel_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    w_sel_we    = (w_pick == REQ_IO) ? WE1 : WE0;
                    owner_d     = w_pick;
                    gnt0_d      = (w_pick == REQ_CPU);
                    gnt1_d      = (w_pick == REQ_IO);
                    mem_read_d  = ~w_sel_we;
                    mem_write_d = w_sel_we;
                    mem_addr_d  = (w_pick == REQ_IO) ? ADDR1  : ADDR0;
                    mem_wdata_d = (w_pick == REQ_IO) ? WDATA1 : WDATA0;
                    lock_lat_d  = (w_pick == REQ_IO) ? LOCK1  : LOCK0;
                    if (w_pick == last_owner_q) begin
                        burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
                    end else begin
                        burst_cnt_d  = 4'd1;
                        last_owner_d = w_pick;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                ack0_d      = (owner_q == REQ_CPU);
                ack1_d      = (owner_q == REQ_IO);
                state_d     = DONE;
            end
            DONE: begin
                ack0_d      = 1'b0;
                ack1_d      = 1'b0;
                gnt0_d      = 1'b0;
                gnt1_d      = 1'b0;
                lock_held_d = lock_lat_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // async clear drops the strobes immediately, so an in-flight write never lands
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q      <= IDLE;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            owner_q      <= REQ_CPU;
            last_owner_q <= REQ_IO;
            burst_cnt_q  <= 4'd0;
            lock_lat_q   <= 1'b0;
            lock_held_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            lock_lat_q   <= lock_lat_d;
            lock_held_q  <= lock_held_d;
        end
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign RDATA     = MEM_OUT;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : transaction-level model + RAM, per-cycle compare, directed tests
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW        = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          CLK    = 1'b0;
    logic          CLR_N  = 1'b0;
    logic          REQ0   = 1'b0, REQ1  = 1'b0;
    logic          WE0    = 1'b0, WE1   = 1'b0;
    logic          LOCK0  = 1'b0, LOCK1 = 1'b0;
    logic [AW-1:0] ADDR0  = '0,   ADDR1 = '0;
    logic [DW-1:0] WDATA0 = '0,   WDATA1 = '0;
    logic          GNT0, GNT1, ACK0, ACK1, MEM_READ, MEM_WRITE;
    logic [DW-1:0] RDATA, MEM_WDATA;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .LOCK0(LOCK0), .LOCK1(LOCK1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_OUT(mem_out)
    );

    always #5 CLK = ~CLK;

    // the RAM the arbiter drives: synchronous write, registered read
    logic [DW-1:0] ram [16];
    always @(posedge CLK) begin
        if (MEM_WRITE) ram[MEM_ADDR] <= MEM_WDATA;
        if (MEM_READ)  mem_out <= ram[MEM_ADDR];
    end

    // transaction model: phase 0 = free, 1 = access cycle, 2 = completion cycle
    int            m_phase;
    bit            m_who, m_we, m_lk, m_last, m_lock;
    int            m_run;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] exp_mem [16];
    int            mlog[$];
    bit            w;

    always @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            m_phase <= 0; m_who <= 1'b0; m_we <= 1'b0; m_lk <= 1'b0;
            m_last  <= 1'b1; m_lock <= 1'b0; m_run <= 0;
            m_addr  <= '0; m_wdata <= '0;
        end else begin
            case (m_phase)
                0: if (REQ0 || REQ1) begin
                    if (REQ0 && !REQ1)                      w = 1'b0;
                    else if (REQ1 && !REQ0)                 w = 1'b1;
                    else if (m_lock && m_run < MAX_BURST)   w = m_last;
                    else                                    w = !m_last;
                    m_run   <= (w == m_last) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
                    m_last  <= w;
                    m_who   <= w;
                    m_we    <= w ? WE1 : WE0;
                    m_lk    <= w ? LOCK1 : LOCK0;
                    m_addr  <= w ? ADDR1 : ADDR0;
                    m_wdata <= w ? WDATA1 : WDATA0;
                    mlog.push_back(int'(w));
                    m_phase <= 1;
                end
                1: begin
                    if (m_we) exp_mem[m_addr] <= m_wdata;
                    m_phase <= 2;
                end
                default: begin
                    m_lock  <= m_lk;
                    m_phase <= 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, every output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("gnt0",  32'(GNT0),      32'(m_phase != 0 && !m_who));
            check("gnt1",  32'(GNT1),      32'(m_phase != 0 &&  m_who));
            check("ack0",  32'(ACK0),      32'(m_phase == 2 && !m_who));
            check("ack1",  32'(ACK1),      32'(m_phase == 2 &&  m_who));
            check("rd",    32'(MEM_READ),  32'(m_phase == 1 && !m_we));
            check("wr",    32'(MEM_WRITE), 32'(m_phase == 1 &&  m_we));
            check("addr",  32'(MEM_ADDR),  32'(m_addr));
            check("wdata", 32'(MEM_WDATA), 32'(m_wdata));
            if (m_phase == 2 && !m_we) check("rdata", 32'(RDATA), 32'(exp_mem[m_addr]));
        end
    end

    // observation of DUT activity for the hand-computed checks
    int            cyc = 0;
    int            c_gnt0, c_gnt1, c_rd, c_wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] rd0, rd1;
    int            dlog[$];
    int            acyc[$];
    always @(negedge CLK) begin
        cyc++;
        if (GNT0) c_gnt0++;
        if (GNT1) c_gnt1++;
        if (MEM_READ) c_rd++;
        if (MEM_WRITE) begin c_wr++; wr_addr = MEM_ADDR; end
        if (ACK0) begin dlog.push_back(0); acyc.push_back(cyc); rd0 = RDATA; end
        if (ACK1) begin dlog.push_back(1); acyc.push_back(cyc); rd1 = RDATA; end
    end

    task automatic clear_mon();
        c_gnt0 = 0; c_gnt1 = 0; c_rd = 0; c_wr = 0;
        dlog.delete(); mlog.delete(); acyc.delete();
    endtask

    task automatic drive(input bit who, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
        if (!who) begin REQ0 = req; WE0 = we; ADDR0 = a; WDATA0 = d; LOCK0 = lk; end
        else      begin REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = d; LOCK1 = lk; end
    endtask

    // hold one command for n back-to-back transactions, then drop REQ
    task automatic run_req(input bit who, input int n, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
        int t;
        @(posedge CLK); #1;
        drive(who, 1'b1, we, a, d, lk);
        for (int k = 0; k < n; k++) begin
            t = 0;
            forever begin
                @(negedge CLK);
                if ((who ? ACK1 : ACK0) === 1'b1) break;
                t++;
                if (t > 60) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_timeout requester %0d: got no ACK expected ACK within 60 cycles", who);
                    break;
                end
            end
            @(posedge CLK); #1;
        end
        drive(who, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1 CLR_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 CLR_N = 1'b1;
    endtask

    task automatic check_log(input string name, input int q[$], input int exp[$]);
        check({name, "_len"}, 32'(q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < q.size(); i++)
            check(name, 32'(q[i]), 32'(exp[i]));
    endtask

    initial begin
        int t;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 8'h10 + 8'(i);
            exp_mem[i] = 8'h10 + 8'(i);
        end
        mem_out = '0;
        @(posedge CLK); #1 chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 CLR_N = 1'b1;

        // reset state
        @(negedge CLK);
        check("rst_gnt",  32'({GNT0, GNT1}), 32'd0);
        check("rst_ack",  32'({ACK0, ACK1}), 32'd0);
        check("rst_strb", 32'({MEM_READ, MEM_WRITE}), 32'd0);
        check("rst_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_wdat", 32'(MEM_WDATA), 32'd0);

        // CPU write 0xA5 to address 3
        clear_mon();
        run_req(1'b0, 1, 1'b1, 4'h3, 8'hA5, 1'b0);
        check("wr_gnt0_cycles", 32'(c_gnt0), 32'd2);
        check("wr_strobe_cycles", 32'(c_wr), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'h3);
        check("wr_ram", 32'(ram[3]), 32'hA5);
        check_log("wr_order", dlog, '{0});

        // loader reads address 3 back
        clear_mon();
        run_req(1'b1, 1, 1'b0, 4'h3, 8'h00, 1'b0);
        check("rd_gnt0_cycles", 32'(c_gnt0), 32'd0);
        check("rd_strobe_cycles", 32'(c_rd), 32'd1);
        check("rd_data", 32'(rd1), 32'hA5);

        // simultaneous requests from reset: CPU first, strict alternation
        pulse_reset();
        clear_mon();
        fork
            run_req(1'b0, 2, 1'b0, 4'h1, 8'h00, 1'b0);
            run_req(1'b1, 2, 1'b0, 4'h2, 8'h00, 1'b0);
        join
        check_log("tie_dut", dlog, '{0, 1, 0, 1});
        check_log("tie_model", mlog, '{0, 1, 0, 1});
        for (int i = 1; i < acyc.size(); i++)
            check("tie_spacing", 32'(acyc[i] - acyc[i-1]), 32'd3);
        check("tie_rdata0", 32'(rd0), 32'h11);
        check("tie_rdata1", 32'(rd1), 32'h12);

        // locked CPU burst against a waiting loader
        clear_mon();
        fork
            run_req(1'b0, 5, 1'b0, 4'h4, 8'h00, 1'b1);
            run_req(1'b1, 1, 1'b0, 4'h5, 8'h00, 1'b0);
        join
        check_log("burst_dut", dlog, '{0, 0, 0, 0, 1, 0});
        check_log("burst_model", mlog, '{0, 0, 0, 0, 1, 0});

        // lone CPU is never throttled
        clear_mon();
        run_req(1'b0, 10, 1'b0, 4'h6, 8'h00, 1'b1);
        check_log("lone_dut", dlog, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        // asynchronous clear in the access cycle of a write to 7
        clear_mon();
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 1'b1, 4'h7, 8'h3C, 1'b0);
        t = 0;
        forever begin
            @(negedge CLK);
            if (MEM_WRITE === 1'b1) break;
            t++;
            if (t > 10) begin
                n_checks++; n_fail++;
                $display("FAIL midrst_wait: got no MEM_WRITE expected MEM_WRITE within 10 cycles");
                break;
            end
        end
        #2 CLR_N = 1'b0;
        #1;
        check("midrst_wr", 32'(MEM_WRITE), 32'd0);
        check("midrst_gnt", 32'({GNT0, GNT1}), 32'd0);
        check("midrst_ack", 32'({ACK0, ACK1}), 32'd0);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge CLK); #2 CLR_N = 1'b1;
        check("midrst_ram", 32'(ram[7]), 32'h17);
        check("midrst_noack", 32'(dlog.size()), 32'd0);
        fork
            run_req(1'b0, 1, 1'b0, 4'h7, 8'h00, 1'b0);
            run_req(1'b1, 1, 1'b0, 4'h5, 8'h00, 1'b0);
        join
        check_log("midrst_order", dlog, '{0, 1});
        check("midrst_rd7", 32'(rd0), 32'h17);
        check("midrst_rd5", 32'(rd1), 32'h15);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish before t=100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
